coin_acceptor: RTL and testbench

Front end that drives the vending controller's coin inputs. Synchronises and debounces three raw mechanical coin-chute switches and buffers coins that arrive together or in bursts. Emits each accepted coin as a one-cycle, one-hot pulse on outquarter/outdime/outnickle, which the controller's coin inputs consume. Rejects coins while inhibited or when the buffer is saturated, and keeps a running total of accepted credit.

---
 rtl/coin_acceptor_pkg.sv | 28 ++
 rtl/coin_acceptor_if.sv | 29 ++
 rtl/coin_acceptor_debounce.sv | 64 ++++++
 rtl/coin_acceptor.sv | 156 +++++++++++++++
 tb/tb_coin_acceptor.sv | 426 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/coin_acceptor_pkg.sv
// Shared definitions for the coin acceptor front end: coin values, coin
// indices and the emitter state encoding.
package coin_acceptor_pkg;

    localparam int QUARTER_CENTS = 25;
    localparam int DIME_CENTS    = 10;
    localparam int NICKLE_CENTS  = 5;

    localparam int Q = 2;
    localparam int D = 1;
    localparam int N = 0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PULSE = 2'd1,
        ST_GAP   = 2'd2
    } emit_state_t;

    function automatic int coin_cents(input int idx);
        case (idx)
            Q:       return QUARTER_CENTS;
            D:       return DIME_CENTS;
            N:       return NICKLE_CENTS;
            default: return 0;
        endcase
    endfunction

endpackage

// File: rtl/coin_acceptor_if.sv
// Coin chute inputs, controller coin pulses and status counters of the
// coin acceptor; the acceptor sits on the slave side.
interface coin_acceptor_if #(
    parameter int CNT_W = 16
);
    logic             rawquarter;
    logic             rawdime;
    logic             rawnickle;
    logic             INHIBIT;
    logic             outquarter;
    logic             outdime;
    logic             outnickle;
    logic             REJECT;
    logic [CNT_W-1:0] credit_total;
    logic [CNT_W-1:0] reject_count;
    logic             busy;

    modport master (
        output rawquarter, rawdime, rawnickle, INHIBIT,
        input  outquarter, outdime, outnickle, REJECT,
        input  credit_total, reject_count, busy
    );

    modport slave (
        input  rawquarter, rawdime, rawnickle, INHIBIT,
        output outquarter, outdime, outnickle, REJECT,
        output credit_total, reject_count, busy
    );
endinterface

// File: rtl/coin_acceptor_debounce.sv
// One coin chute line: 2-flop synchroniser, debounce counter, arm flag and
// a single-cycle event on an armed debounced rising edge.
module coin_debounce #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic CLK,
    input  logic RESET,
    input  logic i_raw,
    output logic o_rise
);
    localparam int            CW   = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          r_sync_p0;
    logic          r_sync_p1;
    logic          r_level;
    logic          r_armed;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] r_arm_cnt;
    logic          w_diff;
    logic          w_flip;

    assign w_diff = (r_sync_p1 != r_level);
    assign w_flip = w_diff && (r_cnt == LAST);
    assign o_rise = w_flip && r_armed && r_sync_p1;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_sync_p0 <= 1'b0;
            r_sync_p1 <= 1'b0;
            r_level   <= 1'b0;
            r_armed   <= 1'b0;
            r_cnt     <= '0;
            r_arm_cnt <= '0;
        end else begin
            // stage p0 -> p1: metastability settling
            r_sync_p0 <= i_raw;
            r_sync_p1 <= r_sync_p0;

            if (w_flip) begin
                r_level <= r_sync_p1;
                r_cnt   <= '0;
            end else if (w_diff) begin
                r_cnt <= r_cnt + 1'b1;
            end else begin
                r_cnt <= '0;
            end

            // The first settled level after reset arms the line silently.
            if (!r_armed) begin
                if (w_flip) begin
                    r_armed <= 1'b1;
                end else if (w_diff) begin
                    r_arm_cnt <= '0;
                end else if (r_arm_cnt == LAST) begin
                    r_armed <= 1'b1;
                end else begin
                    r_arm_cnt <= r_arm_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/coin_acceptor.sv
// Coin acceptor front end: debounces three chutes, buffers accepted coins in
// per-coin pending counters and emits them as spaced one-hot pulses.
module coin_acceptor
    import coin_acceptor_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int GAP_CYCLES      = 1,
    parameter int PEND_W          = 3,
    parameter int CNT_W           = 16
) (
    input  logic           CLK,
    input  logic           RESET,
    coin_acceptor_if.slave bus
);
    localparam logic [PEND_W-1:0] PEND_MAX = '1;
    localparam int                GW       = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GW-1:0]     GAP_LAST = GW'(GAP_CYCLES - 1);

    logic [2:0]        w_raw;
    logic [2:0]        w_rise;
    logic [2:0]        w_rej;
    logic [2:0]        w_inc;
    logic [2:0]        w_dec;
    logic [2:0]        w_out_nxt;
    logic              w_any;
    logic [CNT_W-1:0]  w_cents;
    logic [CNT_W-1:0]  w_rej_n;
    emit_state_t       w_state_nxt;
    logic [GW-1:0]     w_gap_nxt;

    logic [PEND_W-1:0] r_pend [3];
    emit_state_t       r_state;
    logic [GW-1:0]     r_gap;
    logic [2:0]        r_out;
    logic              r_reject;
    logic [CNT_W-1:0]  r_credit;
    logic [CNT_W-1:0]  r_rej_cnt;

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                 input logic [CNT_W-1:0] b);
        logic [CNT_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[CNT_W] ? {CNT_W{1'b1}} : s[CNT_W-1:0];
    endfunction

    assign w_raw[Q] = bus.rawquarter;
    assign w_raw[D] = bus.rawdime;
    assign w_raw[N] = bus.rawnickle;

    for (genvar gi = 0; gi < 3; gi++) begin : g_db
        coin_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_db (
            .CLK   (CLK),
            .RESET (RESET),
            .i_raw (w_raw[gi]),
            .o_rise(w_rise[gi])
        );
    end

    assign w_any = (r_pend[Q] != '0) || (r_pend[D] != '0) || (r_pend[N] != '0);

    // A full counter still accepts when the emitter drains it this same cycle.
    always_comb begin
        w_rej = '0;
        w_inc = '0;
        for (int i = 0; i < 3; i++) begin
            w_rej[i] = w_rise[i] && (bus.INHIBIT || ((r_pend[i] == PEND_MAX) && !w_dec[i]));
            w_inc[i] = w_rise[i] && !w_rej[i];
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_gap_nxt   = r_gap;
        w_dec       = '0;
        w_out_nxt   = '0;
        case (r_state)
            ST_IDLE: begin
                if (!bus.INHIBIT && w_any) begin
                    w_state_nxt = ST_PULSE;
                    if (r_pend[Q] != '0) begin
                        w_dec[Q] = 1'b1;
                    end else if (r_pend[D] != '0) begin
                        w_dec[D] = 1'b1;
                    end else begin
                        w_dec[N] = 1'b1;
                    end
                    w_out_nxt = w_dec;
                end
            end
            ST_PULSE: begin
                w_state_nxt = ST_GAP;
                w_gap_nxt   = '0;
            end
            ST_GAP: begin
                if (r_gap == GAP_LAST) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_gap_nxt = r_gap + 1'b1;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        w_cents = '0;
        if (r_out[Q]) begin
            w_cents = CNT_W'(coin_cents(Q));
        end else if (r_out[D]) begin
            w_cents = CNT_W'(coin_cents(D));
        end else if (r_out[N]) begin
            w_cents = CNT_W'(coin_cents(N));
        end
        w_rej_n = CNT_W'({1'b0, w_rej[0]} + {1'b0, w_rej[1]} + {1'b0, w_rej[2]});
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            for (int i = 0; i < 3; i++) begin
                r_pend[i] <= '0;
            end
            r_state   <= ST_IDLE;
            r_gap     <= '0;
            r_out     <= '0;
            r_reject  <= 1'b0;
            r_credit  <= '0;
            r_rej_cnt <= '0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                case ({w_inc[i], w_dec[i]})
                    2'b10:   r_pend[i] <= r_pend[i] + 1'b1;
                    2'b01:   r_pend[i] <= r_pend[i] - 1'b1;
                    default: r_pend[i] <= r_pend[i];
                endcase
            end
            // stage p0: registered pulse and status outputs
            r_state   <= w_state_nxt;
            r_gap     <= w_gap_nxt;
            r_out     <= w_out_nxt;
            r_reject  <= |w_rej;
            r_credit  <= sat_add(r_credit, w_cents);
            r_rej_cnt <= sat_add(r_rej_cnt, w_rej_n);
        end
    end

    assign bus.outquarter   = r_out[Q];
    assign bus.outdime      = r_out[D];
    assign bus.outnickle    = r_out[N];
    assign bus.REJECT       = r_reject;
    assign bus.credit_total = r_credit;
    assign bus.reject_count = r_rej_cnt;
    assign bus.busy         = w_any || (r_state != ST_IDLE);

endmodule

// File: tb/tb_coin_acceptor.sv
// Scoreboard bench for coin_acceptor: expected pulses are queued as coins are
// driven and a monitor pops and compares each pulse the DUT emits.
module tb_coin_acceptor;
    import coin_acceptor_pkg::*;

    localparam int DEB = 16;
    localparam int GAP = 400;
    localparam int PW  = 3;
    localparam int CW  = 16;

    typedef struct {
        int coin;
        int cyc;
    } exp_t;

    logic CLK   = 1'b0;
    logic RESET = 1'b1;
    exp_t exp_q[$];
    int   errors     = 0;
    int   checks     = 0;
    int   cyc        = 0;
    int   last_pulse = -100000;
    int   n_pulse    = 0;
    int   rej_seen   = 0;
    logic [2:0] prev_out = 3'b000;

    always #5 CLK = ~CLK;

    coin_acceptor_if #(.CNT_W(CW)) bus ();

    coin_acceptor #(
        .DEBOUNCE_CYCLES(DEB),
        .GAP_CYCLES     (GAP),
        .PEND_W         (PW),
        .CNT_W          (CW)
    ) dut (
        .CLK  (CLK),
        .RESET(RESET),
        .bus  (bus)
    );

    always @(posedge CLK) begin
        logic [2:0] o;
        logic [2:0] want;
        exp_t       e;
        #1;
        cyc++;
        o = {bus.outquarter, bus.outdime, bus.outnickle};
        if (bus.REJECT) rej_seen++;
        if (o != 3'b000) begin
            n_pulse++;
            checks++;
            if (!$onehot(o) || ((o & prev_out) != 3'b000) || (cyc - last_pulse < GAP + 1)) begin
                errors++;
                $display("FAIL pulse_shape: out=%b prev=%b spacing=%0d, required one-hot, non-adjacent, spacing>=%0d",
                         o, prev_out, cyc - last_pulse, GAP + 1);
            end
            last_pulse = cyc;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_pulse: out=%b at cycle %0d, required no pulse", o, cyc);
            end else begin
                e    = exp_q.pop_front();
                want = 3'b001 << e.coin;
                if ((o !== want) || ((e.cyc >= 0) && (cyc != e.cyc))) begin
                    errors++;
                    $display("FAIL pulse_match: out=%b cycle=%0d, required out=%b cycle=%0d", o, cyc, want, e.cyc);
                end
            end
        end
        prev_out = o;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RESET = 1'b1;
        bus.rawquarter = 1'b0;
        bus.rawdime    = 1'b0;
        bus.rawnickle  = 1'b0;
        bus.INHIBIT    = 1'b0;
        tick(3);
        RESET = 1'b0;
        exp_q.delete();
        rej_seen   = 0;
        last_pulse = -100000;
        tick(30);
    endtask

    task automatic wait_idle(input int lim, input string name);
        bit done;
        done = 1'b0;
        for (int k = 0; k < lim; k++) begin
            @(posedge CLK);
            #2;
            if (!bus.busy && (exp_q.size() == 0)) begin
                done = 1'b1;
                break;
            end
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL %s_timeout: busy=%b queued=%0d after %0d cycles, required idle and drained",
                     name, bus.busy, exp_q.size(), lim);
        end
    endtask

    task automatic test_reset();
        bus.rawquarter = 1'b0;
        bus.rawdime    = 1'b0;
        bus.rawnickle  = 1'b0;
        bus.INHIBIT    = 1'b0;
        RESET = 1'b1;
        tick(4);
        checks++;
        if ({bus.outquarter, bus.outdime, bus.outnickle, bus.REJECT, bus.busy} !== 5'b0) begin
            errors++;
            $display("FAIL reset_flags: q/d/n/rej/busy=%b, required 00000",
                     {bus.outquarter, bus.outdime, bus.outnickle, bus.REJECT, bus.busy});
        end
        checks++;
        if (bus.credit_total !== 16'd0) begin
            errors++;
            $display("FAIL reset_credit: got %0d, required 0", bus.credit_total);
        end
        checks++;
        if (bus.reject_count !== 16'd0) begin
            errors++;
            $display("FAIL reset_rejects: got %0d, required 0", bus.reject_count);
        end
        RESET = 1'b0;
        tick(30);
        checks++;
        if ((n_pulse != 0) || (bus.busy !== 1'b0)) begin
            errors++;
            $display("FAIL reset_quiet: pulses=%0d busy=%b, required 0 and 0", n_pulse, bus.busy);
        end
    endtask

    task automatic test_single_quarter();
        int t0, np;
        do_reset();
        np = n_pulse;
        tick(1);
        t0 = cyc;
        bus.rawquarter = 1'b1;
        exp_q.push_back('{coin: Q, cyc: t0 + DEB + 3});
        wait_idle(2000, "quarter");
        checks++;
        if (bus.credit_total !== 16'd25) begin
            errors++;
            $display("FAIL quarter_credit: got %0d, required 25", bus.credit_total);
        end
        checks++;
        if ((rej_seen != 0) || (bus.reject_count !== 16'd0)) begin
            errors++;
            $display("FAIL quarter_reject: pulses=%0d count=%0d, required 0 and 0", rej_seen, bus.reject_count);
        end
        bus.rawquarter = 1'b0;
        tick(40);
        checks++;
        if (n_pulse - np != 1) begin
            errors++;
            $display("FAIL quarter_count: got %0d pulses, required 1", n_pulse - np);
        end
    endtask

    task automatic test_bounce();
        int np;
        do_reset();
        np = n_pulse;
        exp_q.push_back('{coin: D, cyc: -1});
        for (int r = 0; r < 3; r++) begin
            tick(1);
            bus.rawdime = 1'b1;
            tick(3);
            bus.rawdime = 1'b0;
            tick(2);
        end
        tick(1);
        bus.rawdime = 1'b1;
        wait_idle(2000, "bounce");
        checks++;
        if ((n_pulse - np != 1) || (bus.credit_total !== 16'd10)) begin
            errors++;
            $display("FAIL bounce_single: pulses=%0d credit=%0d, required 1 and 10", n_pulse - np, bus.credit_total);
        end
        bus.rawdime = 1'b0;
        tick(40);
        bus.rawdime = 1'b1;
        tick(10);
        bus.rawdime = 1'b0;
        tick(50);
        checks++;
        if ((n_pulse - np != 1) || (bus.credit_total !== 16'd10) || (bus.busy !== 1'b0)) begin
            errors++;
            $display("FAIL glitch_ignored: pulses=%0d credit=%0d busy=%b, required 1, 10, 0",
                     n_pulse - np, bus.credit_total, bus.busy);
        end
    endtask

    task automatic test_all_three();
        int np;
        do_reset();
        np = n_pulse;
        exp_q.push_back('{coin: Q, cyc: -1});
        exp_q.push_back('{coin: D, cyc: -1});
        exp_q.push_back('{coin: N, cyc: -1});
        tick(1);
        bus.rawquarter = 1'b1;
        bus.rawdime    = 1'b1;
        bus.rawnickle  = 1'b1;
        wait_idle(3000, "all_three");
        checks++;
        if ((n_pulse - np != 3) || (bus.credit_total !== 16'd40)) begin
            errors++;
            $display("FAIL all_three: pulses=%0d credit=%0d, required 3 and 40", n_pulse - np, bus.credit_total);
        end
        bus.rawquarter = 1'b0;
        bus.rawdime    = 1'b0;
        bus.rawnickle  = 1'b0;
        tick(40);
    endtask

    task automatic test_inhibit();
        int  np;
        bit  seen;
        do_reset();
        np = n_pulse;
        tick(1);
        bus.INHIBIT = 1'b1;
        bus.rawdime = 1'b1;
        tick(DEB + 10);
        checks++;
        if ((rej_seen != 1) || (bus.reject_count !== 16'd1) || (bus.credit_total !== 16'd0) || (n_pulse != np)) begin
            errors++;
            $display("FAIL inhibit_dime: rej_pulses=%0d count=%0d credit=%0d pulses=%0d, required 1, 1, 0, 0",
                     rej_seen, bus.reject_count, bus.credit_total, n_pulse - np);
        end
        bus.rawdime = 1'b0;
        tick(30);
        bus.INHIBIT = 1'b0;
        exp_q.push_back('{coin: Q, cyc: -1});
        bus.rawquarter = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 40; k++) begin
            tick(1);
            if (bus.busy) begin
                seen = 1'b1;
                break;
            end
        end
        bus.INHIBIT = 1'b1;
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL inhibit_pending_timeout: busy=%b, required 1 within 40 cycles", bus.busy);
        end
        tick(20);
        checks++;
        if ((n_pulse != np) || (bus.busy !== 1'b1)) begin
            errors++;
            $display("FAIL inhibit_hold: pulses=%0d busy=%b, required 0 and 1", n_pulse - np, bus.busy);
        end
        bus.INHIBIT = 1'b0;
        wait_idle(2000, "inhibit_release");
        checks++;
        if ((n_pulse - np != 1) || (bus.credit_total !== 16'd25) || (bus.reject_count !== 16'd1)) begin
            errors++;
            $display("FAIL inhibit_release: pulses=%0d credit=%0d rejects=%0d, required 1, 25, 1",
                     n_pulse - np, bus.credit_total, bus.reject_count);
        end
        bus.rawquarter = 1'b0;
        tick(30);
    endtask

    task automatic test_saturate();
        int np;
        bit seen;
        do_reset();
        np = n_pulse;
        exp_q.push_back('{coin: Q, cyc: -1});
        tick(1);
        bus.rawquarter = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 60; k++) begin
            @(posedge CLK);
            #2;
            if (n_pulse - np == 1) begin
                seen = 1'b1;
                break;
            end
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL saturate_first_timeout: pulses=%0d, required 1 within 60 cycles", n_pulse - np);
        end
        bus.rawquarter = 1'b0;
        for (int k = 0; k < 7; k++) exp_q.push_back('{coin: N, cyc: -1});
        for (int k = 0; k < 8; k++) begin
            tick(1);
            bus.rawnickle = 1'b1;
            tick(20);
            bus.rawnickle = 1'b0;
            tick(19);
        end
        checks++;
        if ((rej_seen != 1) || (bus.reject_count !== 16'd1) || (n_pulse - np != 1)) begin
            errors++;
            $display("FAIL saturate_reject: rej_pulses=%0d count=%0d pulses=%0d, required 1, 1, 1",
                     rej_seen, bus.reject_count, n_pulse - np);
        end
        wait_idle(5000, "saturate_drain");
        checks++;
        if ((n_pulse - np != 8) || (bus.credit_total !== 16'd60)) begin
            errors++;
            $display("FAIL saturate_drain: pulses=%0d credit=%0d, required 8 and 60", n_pulse - np, bus.credit_total);
        end
    endtask

    task automatic test_hold_high();
        int np;
        @(negedge CLK);
        RESET = 1'b1;
        bus.rawquarter = 1'b1;
        bus.rawdime    = 1'b0;
        bus.rawnickle  = 1'b0;
        bus.INHIBIT    = 1'b0;
        tick(5);
        RESET = 1'b0;
        exp_q.delete();
        rej_seen = 0;
        np = n_pulse;
        tick(60);
        bus.rawquarter = 1'b0;
        tick(40);
        checks++;
        if ((n_pulse != np) || (bus.credit_total !== 16'd0) || (bus.busy !== 1'b0) || (rej_seen != 0)) begin
            errors++;
            $display("FAIL hold_high_phantom: pulses=%0d credit=%0d busy=%b rej=%0d, required 0, 0, 0, 0",
                     n_pulse - np, bus.credit_total, bus.busy, rej_seen);
        end
        exp_q.push_back('{coin: Q, cyc: -1});
        bus.rawquarter = 1'b1;
        wait_idle(2000, "hold_high_real");
        checks++;
        if ((n_pulse - np != 1) || (bus.credit_total !== 16'd25)) begin
            errors++;
            $display("FAIL hold_high_real: pulses=%0d credit=%0d, required 1 and 25", n_pulse - np, bus.credit_total);
        end
        bus.rawquarter = 1'b0;
        tick(30);
    endtask

    task automatic test_reset_mid_pulse();
        int np;
        bit seen;
        do_reset();
        np = n_pulse;
        exp_q.push_back('{coin: D, cyc: -1});
        tick(1);
        bus.rawdime   = 1'b1;
        bus.rawnickle = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 60; k++) begin
            @(posedge CLK);
            #2;
            if (bus.outdime) begin
                seen = 1'b1;
                break;
            end
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL mid_pulse_timeout: outdime=%b, required 1 within 60 cycles", bus.outdime);
        end
        RESET = 1'b1;
        @(posedge CLK);
        #2;
        checks++;
        if (({bus.outquarter, bus.outdime, bus.outnickle, bus.busy} !== 4'b0) || (bus.credit_total !== 16'd0)) begin
            errors++;
            $display("FAIL mid_pulse_reset: q/d/n/busy=%b credit=%0d, required 0000 and 0",
                     {bus.outquarter, bus.outdime, bus.outnickle, bus.busy}, bus.credit_total);
        end
        tick(2);
        RESET = 1'b0;
        tick(60);
        checks++;
        if ((n_pulse - np != 1) || (bus.credit_total !== 16'd0) || (bus.busy !== 1'b0) || (exp_q.size() != 0)) begin
            errors++;
            $display("FAIL mid_pulse_after: pulses=%0d credit=%0d busy=%b queued=%0d, required 1, 0, 0, 0",
                     n_pulse - np, bus.credit_total, bus.busy, exp_q.size());
        end
        bus.rawdime   = 1'b0;
        bus.rawnickle = 1'b0;
        tick(5);
    endtask

    initial begin
        test_reset();
        test_single_quarter();
        test_bounce();
        test_all_three();
        test_inhibit();
        test_saturate();
        test_hold_high();
        test_reset_mid_pulse();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
